// File: rtl/d_format_uop_decoder.sv
// d_format_uop_decoder: decodes the 40 D-format primary opcodes into the
// decoded-instruction header/body, optionally splitting update forms in two.
module d_format_uop_decoder #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int opcodeSize              = 12,
    parameter int regSize                 = 5,
    parameter int immediateSize           = 16,
    parameter int funcUnitCodeSize        = 3,
    parameter int FXUnitId                = 0,
    parameter int CRUnitId                = 3,
    parameter int LSUnitId                = 4,
    parameter int D                       = 2**5,
    parameter int splitUpdateForms        = 1
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               stall_i,
    input  logic [25:0]                        instFormat_i,
    input  logic [5:0]                         instructionOpcode_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic [instructionCounterWidth-1:0] instructionMajId_i,
    output logic                               ready_o,
    output logic                               enable_o,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
    output logic [instMinIdWidth-1:0]          instMinId_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic [1:0]                         op1rw_o,
    output logic [1:0]                         op2rw_o,
    output logic                               op1isReg_o,
    output logic                               op2isReg_o,
    output logic                               immIsExtended_o,
    output logic                               immIsShifted_o,
    output logic [2*regSize+immediateSize-1:0] instructionBody_o
);

    localparam int BodyW = 2 * regSize + immediateSize;
    localparam int PadW  = opcodeSize - 6;
    localparam bit Split = (splitUpdateForms != 0);

    localparam logic [25:0] DFmt = 26'(D);
    localparam logic [funcUnitCodeSize-1:0] FxCode = funcUnitCodeSize'(FXUnitId);
    localparam logic [funcUnitCodeSize-1:0] CrCode = funcUnitCodeSize'(CRUnitId);
    localparam logic [funcUnitCodeSize-1:0] LsCode = funcUnitCodeSize'(LSUnitId);

    localparam logic [1:0] RD = 2'b10;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] RW = 2'b11;

    typedef enum logic {
        ACCEPT,
        SECOND
    } state_t;

    state_t state_q;

    logic                               enable_q;
    logic [opcodeSize-1:0]              opcode_q;
    logic [funcUnitCodeSize-1:0]        fu_q;
    logic [instMinIdWidth-1:0]          minId_q;
    logic [addressWidth-1:0]            addr_q;
    logic                               is64_q;
    logic [PidSize-1:0]                 pid_q;
    logic [TidSize-1:0]                 tid_q;
    logic [instructionCounterWidth-1:0] majId_q;
    logic [1:0]                         op1rw_q;
    logic [1:0]                         op2rw_q;
    logic                               op1isReg_q;
    logic                               op2isReg_q;
    logic                               immExt_q;
    logic                               immShf_q;
    logic [BodyW-1:0]                   body_q;

    logic [5:0] op;
    logic       isTrap;
    logic       isArith;
    logic       isCmp;
    logic       isLogic;
    logic       isLoad;
    logic       isStore;
    logic       isUpd;

    logic                        valid_d;
    logic                        split_d;
    logic [funcUnitCodeSize-1:0] fu_d;
    logic [1:0]                  op1rw_d;
    logic [1:0]                  op2rw_d;
    logic                        op1isReg_d;
    logic                        op2isReg_d;
    logic                        immExt_d;
    logic                        immShf_d;

    logic [BodyW-1:0]     body_d;
    logic [regSize-1:0]   ra_q;
    logic                 unused_instr_bits;

    assign op     = instructionOpcode_i;
    assign body_d = instruction_i[instructionWidth-7 -: BodyW];
    assign ra_q   = body_q[immediateSize +: regSize];

    // Primary opcode is carried separately; the raw copy of it is not needed.
    assign unused_instr_bits = ^instruction_i[instructionWidth-1 -: 6];

    // Sort the primary opcode into its instruction family.
    always_comb begin
        isTrap  = op inside {6'd2, 6'd3};
        isArith = op inside {6'd7, 6'd8, [6'd12:6'd15]};
        isCmp   = op inside {6'd10, 6'd11};
        isLogic = op inside {[6'd24:6'd29]};
        isLoad  = op inside {[6'd32:6'd35], [6'd40:6'd43],
                             6'd46, [6'd48:6'd51]};
        isStore = op inside {[6'd36:6'd39], 6'd44, 6'd45,
                             6'd47, [6'd52:6'd55]};
        isUpd   = op inside {6'd33, 6'd35, 6'd37, 6'd39, 6'd41, 6'd43,
                             6'd45, 6'd49, 6'd51, 6'd53, 6'd55};
    end

    // Operand usage of the first micro-op for each family.
    always_comb begin
        valid_d    = 1'b0;
        fu_d       = FxCode;
        op1rw_d    = 2'b00;
        op2rw_d    = 2'b00;
        op1isReg_d = 1'b1;
        op2isReg_d = 1'b1;
        immExt_d   = 1'b0;
        immShf_d   = 1'b0;
        unique case (1'b1)
            isTrap: begin
                valid_d    = 1'b1;
                op1isReg_d = 1'b0;
                op1rw_d    = RD;
                op2rw_d    = RD;
                immExt_d   = 1'b1;
            end
            isArith: begin
                valid_d    = 1'b1;
                op1rw_d    = WR;
                op2rw_d    = RD;
                immExt_d   = 1'b1;
                // addi/addis treat RA=0 as literal zero.
                op2isReg_d = !(op inside {6'd14, 6'd15});
                immShf_d   = (op == 6'd15);
            end
            isCmp: begin
                // op1 is the BF field: a CR field that gets written.
                valid_d    = 1'b1;
                fu_d       = CrCode;
                op1isReg_d = 1'b0;
                op1rw_d    = WR;
                op2rw_d    = RD;
                immExt_d   = (op == 6'd11);
            end
            isLogic: begin
                valid_d  = 1'b1;
                op1rw_d  = RD;
                op2rw_d  = WR;
                immShf_d = op[0];
            end
            isLoad: begin
                valid_d    = 1'b1;
                fu_d       = LsCode;
                op1rw_d    = WR;
                op2rw_d    = RD;
                immExt_d   = 1'b1;
                op2isReg_d = isUpd;
            end
            isStore: begin
                valid_d    = 1'b1;
                fu_d       = LsCode;
                op1rw_d    = RD;
                op2rw_d    = RD;
                immExt_d   = 1'b1;
                op2isReg_d = isUpd;
            end
            default: begin
            end
        endcase
        // Unsplit update forms also write RA back in the same op.
        if (isUpd && !Split) begin
            op2rw_d = RW;
        end
        split_d = isUpd && Split;
        if (instFormat_i != DFmt) begin
            valid_d = 1'b0;
        end
    end

    assign ready_o = (state_q == ACCEPT) && !stall_i;

    // Sequencer and registered outputs; a stall freezes everything.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ACCEPT;
            enable_q   <= 1'b0;
            opcode_q   <= '0;
            fu_q       <= '0;
            minId_q    <= '0;
            addr_q     <= '0;
            is64_q     <= 1'b0;
            pid_q      <= '0;
            tid_q      <= '0;
            majId_q    <= '0;
            op1rw_q    <= 2'b00;
            op2rw_q    <= 2'b00;
            op1isReg_q <= 1'b0;
            op2isReg_q <= 1'b0;
            immExt_q   <= 1'b0;
            immShf_q   <= 1'b0;
            body_q     <= '0;
        end else if (!stall_i) begin
            unique case (state_q)
                ACCEPT: begin
                    enable_q <= enable_i && valid_d;
                    if (enable_i && valid_d) begin
                        opcode_q   <= {op, {PadW{1'b0}}};
                        fu_q       <= fu_d;
                        minId_q    <= '0;
                        addr_q     <= instructionAddress_i;
                        is64_q     <= is64Bit_i;
                        pid_q      <= instructionPid_i;
                        tid_q      <= instructionTid_i;
                        majId_q    <= instructionMajId_i;
                        op1rw_q    <= op1rw_d;
                        op2rw_q    <= op2rw_d;
                        op1isReg_q <= op1isReg_d;
                        op2isReg_q <= op2isReg_d;
                        immExt_q   <= immExt_d;
                        immShf_q   <= immShf_d;
                        body_q     <= body_d;
                        if (split_d) begin
                            state_q <= SECOND;
                        end
                    end
                end
                SECOND: begin
                    // RA update: RA <- RA + EXTS(imm) on the fixed-point unit.
                    enable_q   <= 1'b1;
                    opcode_q   <= {opcode_q[opcodeSize-1 -: 6], PadW'(1)};
                    fu_q       <= FxCode;
                    minId_q    <= instMinIdWidth'(1);
                    op1rw_q    <= WR;
                    op2rw_q    <= RD;
                    op1isReg_q <= 1'b1;
                    op2isReg_q <= 1'b1;
                    immExt_q   <= 1'b1;
                    immShf_q   <= 1'b0;
                    body_q     <= {ra_q, ra_q, body_q[immediateSize-1:0]};
                    state_q    <= ACCEPT;
                end
                default: begin
                    state_q <= ACCEPT;
                end
            endcase
        end
    end

    assign enable_o             = enable_q;
    assign opcode_o             = opcode_q;
    assign functionalUnitType_o = fu_q;
    assign instMinId_o          = minId_q;
    assign instructionAddress_o = addr_q;
    assign is64Bit_o            = is64_q;
    assign instPid_o            = pid_q;
    assign instTid_o            = tid_q;
    assign instMajId_o          = majId_q;
    assign op1rw_o              = op1rw_q;
    assign op2rw_o              = op2rw_q;
    assign op1isReg_o           = op1isReg_q;
    assign op2isReg_o           = op2isReg_q;
    assign immIsExtended_o      = immExt_q;
    assign immIsShifted_o       = immShf_q;
    assign instructionBody_o    = body_q;

endmodule

// File: tb/tb_d_format_uop_decoder.sv
// tb_d_format_uop_decoder: scoreboard bench driving an unsplit and a split
// decoder side by side with shared stimulus.
module tb_d_format_uop_decoder;

    typedef struct packed {
        logic [11:0] opc;
        logic [2:0]  fu;
        logic [6:0]  mid;
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic        i1;
        logic        i2;
        logic        ext;
        logic        shf;
        logic [25:0] body;
        logic [63:0] maj;
    } uop_t;

    typedef struct {
        logic [5:0]  op;
        logic [25:0] fmt;
        logic [31:0] ins;
        logic [63:0] maj;
        logic        vld;
        logic        upd;
        uop_t        e;
        uop_t        e1;
    } vec_t;

    localparam logic [25:0] DF = 26'd32;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic        stall;
    logic [25:0] fmt;
    logic [5:0]  opc_i;
    logic [31:0] ins;
    logic [63:0] addr;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] maj;

    logic a_ready, a_en, a_is64, a_i1, a_i2, a_ext, a_shf;
    logic [11:0] a_opc;
    logic [2:0]  a_fu;
    logic [6:0]  a_mid;
    logic [63:0] a_addr, a_maj;
    logic [19:0] a_pid;
    logic [15:0] a_tid;
    logic [1:0]  a_r1, a_r2;
    logic [25:0] a_body;

    logic b_ready, b_en, b_is64, b_i1, b_i2, b_ext, b_shf;
    logic [11:0] b_opc;
    logic [2:0]  b_fu;
    logic [6:0]  b_mid;
    logic [63:0] b_addr, b_maj;
    logic [19:0] b_pid;
    logic [15:0] b_tid;
    logic [1:0]  b_r1, b_r2;
    logic [25:0] b_body;

    uop_t got0, got1, last0;
    uop_t q0[$];
    uop_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   p0 = 0;
    int   p1 = 0;
    logic stall_seen = 1'b0;

    always #5 clk = ~clk;

    d_format_uop_decoder #(.splitUpdateForms(0)) dut0 (
        .clock_i(clk), .reset_i(rst), .enable_i(en_i), .stall_i(stall),
        .instFormat_i(fmt), .instructionOpcode_i(opc_i), .instruction_i(ins),
        .instructionAddress_i(addr), .is64Bit_i(is64),
        .instructionPid_i(pid), .instructionTid_i(tid),
        .instructionMajId_i(maj),
        .ready_o(a_ready), .enable_o(a_en), .opcode_o(a_opc),
        .functionalUnitType_o(a_fu), .instMinId_o(a_mid),
        .instructionAddress_o(a_addr), .is64Bit_o(a_is64),
        .instPid_o(a_pid), .instTid_o(a_tid), .instMajId_o(a_maj),
        .op1rw_o(a_r1), .op2rw_o(a_r2), .op1isReg_o(a_i1), .op2isReg_o(a_i2),
        .immIsExtended_o(a_ext), .immIsShifted_o(a_shf),
        .instructionBody_o(a_body)
    );

    d_format_uop_decoder #(.splitUpdateForms(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .enable_i(en_i), .stall_i(stall),
        .instFormat_i(fmt), .instructionOpcode_i(opc_i), .instruction_i(ins),
        .instructionAddress_i(addr), .is64Bit_i(is64),
        .instructionPid_i(pid), .instructionTid_i(tid),
        .instructionMajId_i(maj),
        .ready_o(b_ready), .enable_o(b_en), .opcode_o(b_opc),
        .functionalUnitType_o(b_fu), .instMinId_o(b_mid),
        .instructionAddress_o(b_addr), .is64Bit_o(b_is64),
        .instPid_o(b_pid), .instTid_o(b_tid), .instMajId_o(b_maj),
        .op1rw_o(b_r1), .op2rw_o(b_r2), .op1isReg_o(b_i1), .op2isReg_o(b_i2),
        .immIsExtended_o(b_ext), .immIsShifted_o(b_shf),
        .instructionBody_o(b_body)
    );

    assign got0 = {a_opc, a_fu, a_mid, a_r1, a_r2, a_i1, a_i2,
                   a_ext, a_shf, a_body, a_maj};
    assign got1 = {b_opc, b_fu, b_mid, b_r1, b_r2, b_i1, b_i2,
                   b_ext, b_shf, b_body, b_maj};

    task automatic chkv(input string nm, input logic [127:0] g,
                        input logic [127:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, g, e);
        end
    endtask

    task automatic chku(input string nm, input uop_t g, input uop_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, g, e);
        end
    endtask

    function automatic uop_t u(input logic [11:0] o, input logic [2:0] f,
                               input logic [6:0] m, input logic [1:0] r1,
                               input logic [1:0] r2, input logic i1,
                               input logic i2, input logic x, input logic s,
                               input logic [25:0] b, input logic [63:0] mj);
        return {o, f, m, r1, r2, i1, i2, x, s, b, mj};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] im);
        return {o, a, b, im};
    endfunction

    function automatic logic isvalid(input logic [5:0] o);
        case (o) inside
            2, 3, 7, 8, [10:15], [24:29], [32:55]: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic isupd(input logic [5:0] o);
        return (o >= 6'd32) && (o <= 6'd55) && o[0] && (o != 6'd47);
    endfunction

    // Reference behaviour of the first micro-op (split decoder view).
    function automatic uop_t model(input logic [5:0] o, input logic [31:0] i,
                                   input logic [63:0] mj);
        uop_t r;
        r = '0;
        r.opc = {o, 6'd0};
        r.body = i[25:0];
        r.maj = mj;
        r.i1 = 1'b1;
        r.i2 = 1'b1;
        r.ext = 1'b1;
        case (o) inside
            2, 3: begin
                r.i1 = 1'b0; r.r1 = 2'b10; r.r2 = 2'b10;
            end
            7, 8, [12:15]: begin
                r.r1 = 2'b01; r.r2 = 2'b10;
                r.i2 = (o < 6'd14);
                r.shf = (o == 6'd15);
            end
            10, 11: begin
                r.fu = 3'd3; r.i1 = 1'b0; r.r1 = 2'b01; r.r2 = 2'b10;
                r.ext = (o == 6'd11);
            end
            [24:29]: begin
                r.r1 = 2'b10; r.r2 = 2'b01; r.ext = 1'b0;
                r.shf = (o == 25 || o == 27 || o == 29);
            end
            [32:35], [40:43], 46, [48:51]: begin
                r.fu = 3'd4; r.r1 = 2'b01; r.r2 = 2'b10; r.i2 = isupd(o);
            end
            default: begin
                r.fu = 3'd4; r.r1 = 2'b10; r.r2 = 2'b10; r.i2 = isupd(o);
            end
        endcase
        return r;
    endfunction

    function automatic uop_t second(input uop_t f);
        return u({f.opc[11:6], 6'd1}, 3'd0, 7'd1, 2'b01, 2'b10, 1'b1, 1'b1,
                 1'b1, 1'b0, {f.body[20:16], f.body[20:16], f.body[15:0]},
                 f.maj);
    endfunction

    always @(posedge clk) stall_seen <= stall;

    // Scoreboard for the unsplit decoder.
    always @(negedge clk) begin
        if (!rst && !stall_seen && a_en) begin
            p0++;
            if (q0.size() == 0) chku("dut0_unexpected", got0, '0);
            else chku("dut0_uop", got0, q0.pop_front());
        end
    end

    // Scoreboard for the split decoder.
    always @(negedge clk) begin
        if (!rst && !stall_seen && b_en) begin
            p1++;
            if (q1.size() == 0) chku("dut1_unexpected", got1, '0);
            else chku("dut1_uop", got1, q1.pop_front());
        end
    end

    task automatic issue(input vec_t v);
        uop_t e0;
        int n;
        e0 = v.e;
        if (v.upd) e0.r2 = 2'b11;
        n = 0;
        while (!b_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!b_ready) chkv("ready_timeout", {127'd0, b_ready}, 128'd1);
        opc_i = v.op;
        fmt = v.fmt;
        ins = v.ins;
        maj = v.maj;
        en_i = 1'b1;
        if (v.vld) begin
            q0.push_back(e0);
            q1.push_back(v.e);
            if (v.upd) q1.push_back(v.e1);
        end
        @(posedge clk);
        #1 en_i = 1'b0;
        @(negedge clk);
        if (v.vld && v.upd) chkv("ready_low_second", {127'd0, b_ready}, 128'd0);
        if (!v.vld) begin
            chkv("invalid_en", {127'd0, a_en}, 128'd0);
            chku("invalid_hold", got0, last0);
        end else begin
            last0 = e0;
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    vec_t tbl[13];
    vec_t v;
    uop_t es, es0;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en_i = 1'b0; stall = 1'b0; fmt = DF; opc_i = '0;
        ins = '0; addr = 64'h0000_1000_2000_3000; is64 = 1'b1;
        pid = 20'h12345; tid = 16'hBEEF; maj = '0; last0 = '0;

        tbl[0]  = '{6'd15, DF, mk(15, 5, 0, 16'h8000), 64'd100, 1, 0,
                    u(12'h3C0, 0, 0, 2'b01, 2'b10, 1, 0, 1, 1,
                      {5'd5, 5'd0, 16'h8000}, 100), '0};
        tbl[1]  = '{6'd33, DF, mk(33, 3, 4, 16'h0010), 64'd7, 1, 1,
                    u(12'h840, 4, 0, 2'b01, 2'b10, 1, 1, 1, 0,
                      {5'd3, 5'd4, 16'h0010}, 7),
                    u(12'h841, 0, 1, 2'b01, 2'b10, 1, 1, 1, 0,
                      {5'd4, 5'd4, 16'h0010}, 7)};
        tbl[2]  = '{6'd24, DF, mk(24, 6, 7, 16'h00FF), 64'd8, 1, 0,
                    u(12'h600, 0, 0, 2'b10, 2'b01, 1, 1, 0, 0,
                      {5'd6, 5'd7, 16'h00FF}, 8), '0};
        tbl[3]  = '{6'd25, DF, mk(25, 6, 7, 16'hF0F0), 64'd9, 1, 0,
                    u(12'h640, 0, 0, 2'b10, 2'b01, 1, 1, 0, 1,
                      {5'd6, 5'd7, 16'hF0F0}, 9), '0};
        tbl[4]  = '{6'd11, DF, mk(11, 4, 9, 16'hFFFE), 64'd10, 1, 0,
                    u(12'h2C0, 3, 0, 2'b01, 2'b10, 0, 1, 1, 0,
                      {5'd4, 5'd9, 16'hFFFE}, 10), '0};
        tbl[5]  = '{6'd10, DF, mk(10, 8, 9, 16'h7FFF), 64'd11, 1, 0,
                    u(12'h280, 3, 0, 2'b01, 2'b10, 0, 1, 0, 0,
                      {5'd8, 5'd9, 16'h7FFF}, 11), '0};
        tbl[6]  = '{6'd3, DF, mk(3, 4, 2, 16'h0003), 64'd12, 1, 0,
                    u(12'h0C0, 0, 0, 2'b10, 2'b10, 0, 1, 1, 0,
                      {5'd4, 5'd2, 16'h0003}, 12), '0};
        tbl[7]  = '{6'd36, DF, mk(36, 2, 1, 16'h0008), 64'd13, 1, 0,
                    u(12'h900, 4, 0, 2'b10, 2'b10, 1, 0, 1, 0,
                      {5'd2, 5'd1, 16'h0008}, 13), '0};
        tbl[8]  = '{6'd14, 26'd16, mk(14, 1, 2, 16'h0001), 64'd14, 0, 0,
                    '0, '0};
        tbl[9]  = '{6'd37, DF, mk(37, 2, 1, 16'hFFF0), 64'd15, 1, 1,
                    u(12'h940, 4, 0, 2'b10, 2'b10, 1, 1, 1, 0,
                      {5'd2, 5'd1, 16'hFFF0}, 15),
                    u(12'h941, 0, 1, 2'b01, 2'b10, 1, 1, 1, 0,
                      {5'd1, 5'd1, 16'hFFF0}, 15)};
        tbl[10] = '{6'd46, DF, mk(46, 28, 0, 16'h0040), 64'd16, 1, 0,
                    u(12'hB80, 4, 0, 2'b01, 2'b10, 1, 0, 1, 0,
                      {5'd28, 5'd0, 16'h0040}, 16), '0};
        tbl[11] = '{6'd4, DF, mk(4, 1, 1, 16'h0001), 64'd17, 0, 0,
                    '0, '0};
        tbl[12] = '{6'd7, DF, mk(7, 31, 30, 16'h8001), 64'd18, 1, 0,
                    u(12'h1C0, 0, 0, 2'b01, 2'b10, 1, 1, 1, 0,
                      {5'd31, 5'd30, 16'h8001}, 18), '0};

        repeat (2) @(negedge clk);
        chku("reset_dut0", got0, '0);
        chku("reset_dut1", got1, '0);
        chkv("reset_en", {126'd0, a_en, b_en}, 128'd0);
        chkv("reset_side0", {a_addr, a_is64, a_pid, a_tid}, 128'd0);
        chkv("reset_side1", {b_addr, b_is64, b_pid, b_tid}, 128'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chkv("ready_after_reset", {126'd0, a_ready, b_ready}, 128'd3);
        #1;

        for (int k = 0; k < 13; k++) issue(tbl[k]);

        p0 = 0;
        p1 = 0;
        for (int k = 0; k < 64; k++) begin
            v.op = 6'(k);
            v.fmt = DF;
            v.ins = mk(6'(k), 5'($urandom), 5'($urandom_range(0, 3)),
                       16'($urandom));
            v.maj = 64'(1000 + k);
            v.vld = isvalid(v.op);
            v.upd = isupd(v.op);
            v.e = model(v.op, v.ins, v.maj);
            v.e1 = second(v.e);
            issue(v);
        end
        chkv("sweep_pulses_split0", 128'(p0), 128'd40);
        chkv("sweep_pulses_split1", 128'(p1), 128'd51);

        es = u(12'h940, 4, 0, 2'b10, 2'b10, 1, 1, 1, 0,
               {5'd2, 5'd1, 16'h0040}, 55);
        es0 = es;
        es0.r2 = 2'b11;
        opc_i = 6'd37; fmt = DF; ins = mk(37, 2, 1, 16'h0040); maj = 64'd55;
        q0.push_back(es0);
        q1.push_back(es);
        q1.push_back(u(12'h941, 0, 1, 2'b01, 2'b10, 1, 1, 1, 0,
                       {5'd1, 5'd1, 16'h0040}, 55));
        en_i = 1'b1;
        @(posedge clk);
        #1 en_i = 1'b0;
        stall = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chku("stall_hold", got1, es);
            chkv("stall_en", {127'd0, b_en}, 128'd1);
            chkv("stall_ready", {127'd0, b_ready}, 128'd0);
        end
        #1 stall = 1'b0;
        @(negedge clk);
        chkv("minor1_after_stall", 128'(b_mid), 128'd1);
        @(negedge clk);
        chkv("no_duplicate", {127'd0, b_en}, 128'd0);
        chkv("ready_back", {127'd0, b_ready}, 128'd1);
        last0 = es0;
        #1;

        es = u(12'h8C0, 4, 0, 2'b01, 2'b10, 1, 1, 1, 0,
               {5'd8, 5'd9, 16'h1234}, 77);
        es0 = es;
        es0.r2 = 2'b11;
        opc_i = 6'd35; ins = mk(35, 8, 9, 16'h1234); maj = 64'd77;
        q0.push_back(es0);
        q1.push_back(es);
        en_i = 1'b1;
        @(posedge clk);
        #1 en_i = 1'b0;
        @(negedge clk);
        chkv("in_second", {127'd0, b_ready}, 128'd0);
        #1 rst = 1'b1;
        #1;
        chku("reset_mid_second", got1, '0);
        chkv("reset_mid_en", {127'd0, b_en}, 128'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        last0 = '0;
        repeat (3) begin
            @(negedge clk);
            chkv("no_minor1_after_reset", {127'd0, b_en}, 128'd0);
        end
        chkv("ready_after_mid_reset", {127'd0, b_ready}, 128'd1);

        repeat (3) @(negedge clk);
        chkv("q0_drained", 128'(q0.size()), 128'd0);
        chkv("q1_drained", 128'(q1.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
